// File: rtl/aiv_sync_decoder_pkg.sv
// Shared thresholds, pulse-class codes and lock-state codes for the AIV composite sync decoder.
// Default thresholds assume sysClk = 81 MHz (6x pixel clock) and PAL 625/50 timing.
package aiv_sync_decoder_pkg;

  localparam int DEF_GLITCH_CYCLES = 4;
  localparam int DEF_EQ_MAX        = 285;
  localparam int DEF_HS_MAX        = 810;
  localparam int DEF_HALF_MAX      = 3888;
  localparam int DEF_LINES_MIN     = 300;
  localparam int DEF_LINES_MAX     = 320;
  localparam int DEF_TIMEOUT       = 10368;

  localparam int CNT_W  = 14;
  localparam int LINE_W = 10;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_EQ    = 2'd1,
    CLS_HS    = 2'd2,
    CLS_BROAD = 2'd3
  } pulse_cls_e;

  typedef enum logic {
    LOCK_SEARCH = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  function automatic pulse_cls_e classify_pulse(input logic [CNT_W-1:0] width,
                                                input logic [CNT_W-1:0] eq_max,
                                                input logic [CNT_W-1:0] hs_max);
    pulse_cls_e cls;
    if (width < eq_max)      cls = CLS_EQ;
    else if (width < hs_max) cls = CLS_HS;
    else                     cls = CLS_BROAD;
    return cls;
  endfunction

endpackage

// File: rtl/aiv_sync_decoder_glitch_filter.sv
// Two-flop synchroniser plus stability filter; level_o follows async_i once it has held a new
// value for GLITCH_CYCLES cycles, giving 2+GLITCH_CYCLES cycles of edge latency.
module sync_glitch_filter #(
  parameter int   GLITCH_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o
);

  localparam int CW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(GLITCH_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= {2{RESET_LEVEL}};
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      if (sync_q[1] != level_q) begin
        if (cnt_q == LAST) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/aiv_sync_decoder.sv
// Composite-sync decoder: classifies filtered low pulses into EQ/HS/BROAD and derives hsync/vsync
// strobes, field identity, line counts and lock; strobes appear one cycle after the filtered rising edge.
module aiv_sync_decoder
  import aiv_sync_decoder_pkg::*;
#(
  parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES,
  parameter int EQ_MAX        = DEF_EQ_MAX,
  parameter int HS_MAX        = DEF_HS_MAX,
  parameter int HALF_MAX      = DEF_HALF_MAX,
  parameter int LINES_MIN     = DEF_LINES_MIN,
  parameter int LINES_MAX     = DEF_LINES_MAX,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic              sysClk,
  input  logic              nReset,
  input  logic              csync_in,
  output logic              hsync_pulse,
  output logic              vsync_pulse,
  output logic              field,
  output logic [LINE_W-1:0] lineNumber,
  output logic [LINE_W-1:0] frameLines,
  output logic              locked
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic              filt_lvl;
  logic              prev_q;
  logic              fall, rise, timeout, lines_ok;
  logic [CNT_W-1:0]  width_q, width_d;
  logic [CNT_W-1:0]  period_q, period_d;
  pulse_cls_e        cls;
  logic              hs_pending_q, hs_full_q;
  logic [2:0]        broad_cnt_q;
  logic [1:0]        lock_cnt_q;
  lock_state_e       state_q;
  logic              hsync_q, vsync_q, field_q;
  logic [LINE_W-1:0] line_q, frame_q;

  sync_glitch_filter #(
    .GLITCH_CYCLES(GLITCH_CYCLES),
    .RESET_LEVEL  (1'b1)
  ) u_filt (
    .clk_i  (sysClk),
    .rst_ni (nReset),
    .async_i(csync_in),
    .level_o(filt_lvl)
  );

  always_comb begin
    fall = prev_q & ~filt_lvl;
    rise = ~prev_q & filt_lvl;

    width_d = width_q;
    if (fall)                               width_d = CNT_W'(1);
    else if (!filt_lvl && width_q != CNT_SAT) width_d = width_q + CNT_W'(1);

    period_d = period_q;
    if (fall)                      period_d = '0;
    else if (period_q != CNT_SAT)  period_d = period_q + CNT_W'(1);

    cls      = rise ? classify_pulse(width_q, CNT_W'(EQ_MAX), CNT_W'(HS_MAX)) : CLS_NONE;
    // A falling edge restarts the period, so it always beats a coincident timeout.
    timeout  = !fall && (period_q == CNT_W'(TIMEOUT));
    lines_ok = (line_q >= LINE_W'(LINES_MIN)) && (line_q <= LINE_W'(LINES_MAX));
  end

  always_ff @(posedge sysClk or negedge nReset) begin
    if (!nReset) begin
      prev_q       <= 1'b1;
      width_q      <= '0;
      period_q     <= '0;
      hs_pending_q <= 1'b0;
      hs_full_q    <= 1'b0;
      broad_cnt_q  <= '0;
      lock_cnt_q   <= '0;
      state_q      <= LOCK_SEARCH;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      field_q      <= 1'b0;
      line_q       <= '0;
      frame_q      <= '0;
    end else begin
      prev_q   <= filt_lvl;
      width_q  <= width_d;
      period_q <= period_d;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;

      // period_q holds interval-1 at a falling edge.
      if (fall && hs_pending_q) begin
        hs_full_q    <= (period_q >= CNT_W'(HALF_MAX - 1));
        hs_pending_q <= 1'b0;
      end

      if (timeout) begin
        state_q     <= LOCK_SEARCH;
        lock_cnt_q  <= '0;
        line_q      <= '0;
        broad_cnt_q <= '0;
      end else begin
        case (cls)
          CLS_HS: begin
            hsync_q      <= 1'b1;
            hs_pending_q <= 1'b1;
            broad_cnt_q  <= '0;
            if (line_q != '1) line_q <= line_q + LINE_W'(1);
          end
          CLS_BROAD: begin
            if (broad_cnt_q != 3'd7) broad_cnt_q <= broad_cnt_q + 3'd1;
            if (broad_cnt_q == 3'd2) begin
              vsync_q <= 1'b1;
              field_q <= hs_full_q;
              frame_q <= line_q;
              line_q  <= '0;
              if (lines_ok) begin
                lock_cnt_q <= (lock_cnt_q == 2'd2) ? 2'd2 : lock_cnt_q + 2'd1;
                if (lock_cnt_q != 2'd0) state_q <= LOCK_LOCKED;
              end else begin
                lock_cnt_q <= '0;
                state_q    <= LOCK_SEARCH;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hsync_pulse = hsync_q;
  assign vsync_pulse = vsync_q;
  assign field       = field_q;
  assign lineNumber  = line_q;
  assign frameLines  = frame_q;
  assign locked      = (state_q == LOCK_LOCKED);

endmodule

// File: tb/tb_aiv_sync_decoder.sv
// Directed bench for aiv_sync_decoder using thresholds scaled down so whole fields fit in a short run.
// Scaled timing: HS 16 cycles low / 192 period, EQ 8 / 96, BROAD 80 / 96.
module tb_aiv_sync_decoder;

  localparam int GC    = 4;
  localparam int EQM   = 12;
  localparam int HSM   = 30;
  localparam int HALFM = 144;
  localparam int LMIN  = 8;
  localparam int LMAX  = 12;
  localparam int TO    = 400;
  localparam int LINE  = 192;
  localparam int HALF  = 96;

  logic       sysClk   = 1'b0;
  logic       nReset   = 1'b0;
  logic       csync_in = 1'b1;
  logic       hsync_pulse, vsync_pulse, field, locked;
  logic [9:0] lineNumber, frameLines;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_seen  = 0;
  int vs_seen  = 0;
  int hs_cyc   = 0;
  int drive_cyc = 0;
  int hs_base, vs_base;
  bit both_seen     = 1'b0;
  bit filt_low_seen = 1'b0;

  always #5 sysClk = ~sysClk;

  aiv_sync_decoder #(
    .GLITCH_CYCLES(GC), .EQ_MAX(EQM), .HS_MAX(HSM), .HALF_MAX(HALFM),
    .LINES_MIN(LMIN), .LINES_MAX(LMAX), .TIMEOUT(TO)
  ) u_dut (
    .sysClk     (sysClk),
    .nReset     (nReset),
    .csync_in   (csync_in),
    .hsync_pulse(hsync_pulse),
    .vsync_pulse(vsync_pulse),
    .field      (field),
    .lineNumber (lineNumber),
    .frameLines (frameLines),
    .locked     (locked)
  );

  always @(posedge sysClk) cyc <= cyc + 1;

  always @(negedge sysClk) begin
    if (hsync_pulse === 1'b1) begin
      hs_seen = hs_seen + 1;
      hs_cyc  = cyc;
    end
    if (vsync_pulse === 1'b1) vs_seen = vs_seen + 1;
    if (hsync_pulse === 1'b1 && vsync_pulse === 1'b1) both_seen = 1'b1;
    if (u_dut.filt_lvl !== 1'b1) filt_low_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One low pulse of 'low' cycles inside a falling-to-falling period of 'period' cycles.
  task automatic pulse(input int low, input int period);
    @(negedge sysClk);
    csync_in = 1'b0;
    repeat (low) @(negedge sysClk);
    csync_in  = 1'b1;
    drive_cyc = cyc;
    repeat (period - low - 1) @(negedge sysClk);
  endtask

  task automatic lines(input int n, input bit half_last);
    for (int i = 0; i < n; i++) pulse(16, (half_last && i == n - 1) ? HALF : LINE);
  endtask

  task automatic eqs();
    repeat (5) pulse(8, HALF);
  endtask

  task automatic broads(input int k);
    repeat (k) pulse(80, HALF);
  endtask

  task automatic full_field(input int n, input bit half_last);
    lines(n, half_last);
    eqs();
    broads(5);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge sysClk);
    check("rst_hsync",  hsync_pulse, 0);
    check("rst_vsync",  vsync_pulse, 0);
    check("rst_field",  field,       0);
    check("rst_line",   lineNumber,  0);
    check("rst_frame",  frameLines,  0);
    check("rst_locked", locked,      0);
    nReset = 1'b1;
    repeat (5) @(negedge sysClk);

    // 3-cycle glitch must be swallowed by the filter
    pulse(3, 60);
    check("glitch_hs",   hs_seen,       0);
    check("glitch_filt", filt_low_seen, 0);
    check("glitch_line", lineNumber,    0);

    // Width boundaries: 11 is EQ, 12 and 29 are HS, 30 is BROAD
    pulse(11, 60);
    check("eq11_hs", hs_seen, 0);
    pulse(12, 60);
    check("hs12_count",   hs_seen,          1);
    check("hs12_latency", hs_cyc - drive_cyc, 2 + GC + 1);
    check("hs12_line",    lineNumber,       1);
    pulse(29, 60);
    check("hs29_count", hs_seen,    2);
    check("hs29_line",  lineNumber, 2);
    pulse(30, 80);
    check("br30_hs",   hs_seen,    2);
    check("br30_vs",   vs_seen,    0);
    check("br30_line", lineNumber, 2);

    // Field 1: full final line, vsync only on 3rd broad
    nReset = 1'b0;
    repeat (2) @(negedge sysClk);
    nReset = 1'b1;
    check("rst2_line", lineNumber, 0);
    hs_base = hs_seen;
    vs_base = vs_seen;
    lines(10, 1'b0);
    eqs();
    broads(2);
    check("f1_vs_after2", vs_seen - vs_base, 0);
    broads(3);
    check("f1_vs_after5", vs_seen - vs_base, 1);
    check("f1_hs",        hs_seen - hs_base, 10);
    check("f1_frame",     frameLines, 10);
    check("f1_line",      lineNumber, 0);
    check("f1_field",     field,      1);
    check("f1_locked",    locked,     0);

    // Field 2: half-line after last hsync, second in-range field locks
    full_field(10, 1'b1);
    check("f2_frame",  frameLines, 10);
    check("f2_field",  field,      0);
    check("f2_locked", locked,     1);

    // Field 3: too few lines drops lock
    full_field(6, 1'b0);
    check("f3_frame",  frameLines, 6);
    check("f3_field",  field,      1);
    check("f3_locked", locked,     0);

    // Fields 4/5: LINES_MIN then LINES_MAX relock
    full_field(8, 1'b0);
    check("f4_frame",  frameLines, 8);
    check("f4_locked", locked,     0);
    full_field(12, 1'b1);
    check("f5_frame",  frameLines, 12);
    check("f5_field",  field,      0);
    check("f5_locked", locked,     1);

    // Timeout with csync idle high
    lines(3, 1'b0);
    repeat (150) @(negedge sysClk);
    check("to_pre_locked", locked,     1);
    check("to_pre_line",   lineNumber, 3);
    repeat (100) @(negedge sysClk);
    check("to_locked", locked,     0);
    check("to_line",   lineNumber, 0);
    check("to_frame",  frameLines, 12);
    check("to_field",  field,      0);

    // Reset in the middle of a broad pulse, after two broads already counted
    lines(4, 1'b0);
    check("pre_rst_line", lineNumber, 4);
    broads(2);
    vs_base = vs_seen;
    @(negedge sysClk);
    csync_in = 1'b0;
    repeat (40) @(negedge sysClk);
    #2 nReset = 1'b0;
    #1;
    check("mid_rst_line",  lineNumber,  0);
    check("mid_rst_frame", frameLines,  0);
    check("mid_rst_field", field,       0);
    check("mid_rst_lock",  locked,      0);
    check("mid_rst_hs",    hsync_pulse, 0);
    check("mid_rst_vs",    vsync_pulse, 0);
    repeat (20) @(negedge sysClk);
    csync_in = 1'b1;
    repeat (10) @(negedge sysClk);
    nReset = 1'b1;
    broads(2);
    check("post_rst_vs2", vs_seen - vs_base, 0);
    broads(1);
    check("post_rst_vs3", vs_seen - vs_base, 1);
    check("post_rst_frame", frameLines, 0);

    check("hs_vs_overlap", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
